// File: rtl/rmap_pkg.sv
// Shared RMAP definitions: header status codes, parser states, protocol constants and the header CRC.
package rmap_pkg;

    typedef enum logic [2:0] {
        OK        = 3'd0,
        CRC_ERR   = 3'd1,
        EARLY_EOP = 3'd2,
        EARLY_EEP = 3'd3,
        BAD_TYPE  = 3'd4
    } rmap_status_e;

    typedef enum logic [1:0] {
        HEADER  = 2'd0,
        HDR_OUT = 2'd1,
        PAYLOAD = 2'd2,
        DRAIN   = 2'd3
    } parser_state_e;

    localparam logic [7:0] RMAP_PROTOCOL_ID = 8'h01;
    localparam logic [7:0] EOP              = 8'h00;
    localparam logic [7:0] EEP              = 8'h01;

    // Reflected form of x^8+x^2+x+1: the register equals the transmitted CRC byte,
    // so a good header leaves it at zero once the CRC byte has been folded in.
    function automatic logic [7:0] rmap_crc8(input logic [7:0] data, input logic [7:0] crc);
        logic [7:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) c = (c >> 1) ^ 8'hE0;
            else                c = c >> 1;
        end
        return c;
    endfunction

endpackage

// File: rtl/rmap_header_parser.sv
// Parses and CRC-checks an RMAP command header from the rx FIFO, hands the fields to the
// executor over valid/ready, then streams the payload or drains rejected packets.
module rmap_header_parser
    import rmap_pkg::*;
#(
    parameter logic [7:0] LOGICAL_ADDR = 8'hFE
) (
    input  logic        clk,
    input  logic        rstN,
    output logic        rxReadEnable,
    input  logic [8:0]  rxDataOut,
    input  logic        rxEmpty,
    output logic        hdrValid,
    input  logic        hdrReady,
    output logic [2:0]  hdrStatus,
    output logic [7:0]  instruction,
    output logic [7:0]  key,
    output logic [7:0]  initiatorAddr,
    output logic [15:0] transactionId,
    output logic [7:0]  extAddr,
    output logic [31:0] address,
    output logic [23:0] dataLength,
    output logic [95:0] replyAddr,
    output logic [3:0]  replyAddrLen,
    output logic [8:0]  dataOut,
    output logic        dataValid,
    input  logic        dataReady,
    output logic        pktDropped
);

    localparam int unsigned IDX_W = 5;

    parser_state_e    state;
    logic [IDX_W-1:0] idx;
    logic [7:0]       crc;
    logic             drop_pend;

    logic [7:0]       ch_byte;
    logic             ch_ctrl;
    logic [7:0]       crc_next;
    logic [IDX_W-1:0] r_len;
    logic [IDX_W-1:0] off;

    // FIFO pop and payload stream are combinational so the payload path has no latency.
    always_comb begin
        rxReadEnable = 1'b0;
        dataValid    = 1'b0;
        dataOut      = '0;
        ch_byte      = rxDataOut[7:0];
        ch_ctrl      = rxDataOut[8];
        crc_next     = rmap_crc8(ch_byte, crc);
        r_len        = IDX_W'({instruction[1:0], 2'b00});
        off          = idx - r_len;
        case (state)
            HEADER, DRAIN: rxReadEnable = !rxEmpty;
            PAYLOAD: begin
                dataOut      = rxDataOut;
                dataValid    = !rxEmpty;
                rxReadEnable = !rxEmpty && dataReady;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state         <= HEADER;
            idx           <= '0;
            crc           <= '0;
            drop_pend     <= 1'b0;
            hdrValid      <= 1'b0;
            hdrStatus     <= '0;
            instruction   <= '0;
            key           <= '0;
            initiatorAddr <= '0;
            transactionId <= '0;
            extAddr       <= '0;
            address       <= '0;
            dataLength    <= '0;
            replyAddr     <= '0;
            replyAddrLen  <= '0;
            pktDropped    <= 1'b0;
        end else begin
            pktDropped <= 1'b0;
            case (state)
                HEADER: if (rxReadEnable) begin
                    if (ch_ctrl) begin
                        idx <= '0;
                        crc <= '0;
                        if (idx < IDX_W'(2)) begin
                            pktDropped <= 1'b1;
                        end else begin
                            hdrStatus <= (ch_byte == EOP) ? EARLY_EOP : EARLY_EEP;
                            hdrValid  <= 1'b1;
                            state     <= HDR_OUT;
                        end
                    end else begin
                        crc <= crc_next;
                        idx <= idx + 1'b1;
                        if (idx == '0) begin
                            replyAddr <= '0;
                            if (ch_byte != LOGICAL_ADDR) begin
                                state     <= DRAIN;
                                drop_pend <= 1'b1;
                                crc       <= '0;
                                idx       <= '0;
                            end
                        end else if (idx == IDX_W'(1)) begin
                            if (ch_byte != RMAP_PROTOCOL_ID) begin
                                state     <= DRAIN;
                                drop_pend <= 1'b1;
                                crc       <= '0;
                                idx       <= '0;
                            end
                        end else if (idx == IDX_W'(2)) begin
                            instruction  <= ch_byte;
                            replyAddrLen <= {ch_byte[1:0], 2'b00};
                        end else if (idx == IDX_W'(3)) begin
                            key <= ch_byte;
                        end else if (idx < r_len + IDX_W'(4)) begin
                            replyAddr <= {replyAddr[87:0], ch_byte};
                        end else begin
                            // Remaining fields sit at fixed offsets once the reply address is skipped.
                            case (off)
                                IDX_W'(4): initiatorAddr <= ch_byte;
                                IDX_W'(5), IDX_W'(6): transactionId <= {transactionId[7:0], ch_byte};
                                IDX_W'(7): extAddr <= ch_byte;
                                IDX_W'(8), IDX_W'(9), IDX_W'(10), IDX_W'(11):
                                    address <= {address[23:0], ch_byte};
                                IDX_W'(12), IDX_W'(13), IDX_W'(14):
                                    dataLength <= {dataLength[15:0], ch_byte};
                                IDX_W'(15): begin
                                    idx      <= '0;
                                    crc      <= '0;
                                    hdrValid <= 1'b1;
                                    state    <= HDR_OUT;
                                    if (crc_next != 8'h00)           hdrStatus <= CRC_ERR;
                                    else if (instruction[7:6] != 2'b01) hdrStatus <= BAD_TYPE;
                                    else                             hdrStatus <= OK;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                HDR_OUT: if (hdrReady) begin
                    hdrValid <= 1'b0;
                    case (hdrStatus)
                        OK:                state <= PAYLOAD;
                        CRC_ERR, BAD_TYPE: begin
                            state     <= DRAIN;
                            drop_pend <= 1'b0;
                        end
                        default:           state <= HEADER;
                    endcase
                end
                PAYLOAD: if (rxReadEnable && ch_ctrl) begin
                    state <= HEADER;
                end
                DRAIN: if (rxReadEnable && ch_ctrl) begin
                    state      <= HEADER;
                    pktDropped <= drop_pend;
                    drop_pend  <= 1'b0;
                end
                default: state <= HEADER;
            endcase
        end
    end

endmodule

// File: tb/tb_rmap_header_parser.sv
// Randomized scoreboard bench for rmap_header_parser: a FIFO model feeds packets, a packet-level
// reference model predicts headers, payload and drops, and a monitor checks what the DUT presents.
module tb_rmap_header_parser;

    localparam logic [7:0] LA = 8'hFE;

    typedef logic [8:0] chr_q_t [$];
    typedef struct {
        logic [2:0]  status;
        bit          full;
        logic [7:0]  instr, key, init, ext;
        logic [15:0] tid;
        logic [31:0] addr;
        logic [23:0] len;
        logic [95:0] raddr;
        logic [3:0]  rlen;
    } exp_hdr_t;

    logic        clk, rstN;
    logic        rxReadEnable, rxEmpty, hdrValid, hdrReady, dataValid, dataReady, pktDropped;
    logic [8:0]  rxDataOut, dataOut;
    logic [2:0]  hdrStatus;
    logic [7:0]  instruction, key, initiatorAddr, extAddr;
    logic [15:0] transactionId;
    logic [31:0] address;
    logic [23:0] dataLength;
    logic [95:0] replyAddr;
    logic [3:0]  replyAddrLen;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    chr_q_t   fifo;
    exp_hdr_t exp_hdr[$];
    logic [8:0] exp_data[$];
    int       exp_drop[$];

    int  gap_mode = 0, hr_mode = 0, dr_mode = 0, dready_low = 0;
    bit  gap_tog = 0, pop_pending = 0, arm_first = 0;
    int  first_pop_cyc = 0, hdr_lat = -1;
    logic [95:0] last_raddr = '0;
    logic [3:0]  last_rlen = '0;

    rmap_header_parser #(.LOGICAL_ADDR(LA)) dut (
        .clk(clk), .rstN(rstN), .rxReadEnable(rxReadEnable), .rxDataOut(rxDataOut),
        .rxEmpty(rxEmpty), .hdrValid(hdrValid), .hdrReady(hdrReady), .hdrStatus(hdrStatus),
        .instruction(instruction), .key(key), .initiatorAddr(initiatorAddr),
        .transactionId(transactionId), .extAddr(extAddr), .address(address),
        .dataLength(dataLength), .replyAddr(replyAddr), .replyAddrLen(replyAddrLen),
        .dataOut(dataOut), .dataValid(dataValid), .dataReady(dataReady), .pktDropped(pktDropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return r;
    endfunction

    // Bytewise MSB-first division by 0x07 over bit-reversed bytes; result reversed back.
    function automatic logic [7:0] model_crc(input chr_q_t p, input int n);
        logic [7:0] t;
        t = 8'h00;
        for (int i = 0; i < n; i++) begin
            t = t ^ rev8(p[i][7:0]);
            for (int k = 0; k < 8; k++) t = t[7] ? ((t << 1) ^ 8'h07) : (t << 1);
        end
        return rev8(t);
    endfunction

    function automatic chr_q_t build_pkt(input logic [7:0] tla, input logic [7:0] pid,
                                         input logic [7:0] instr, input logic [95:0] rv,
                                         input logic [15:0] tid, input logic [31:0] addr,
                                         input logic [23:0] len, input logic [7:0] crc_xor,
                                         input int ndata, input logic [7:0] term);
        chr_q_t p;
        int r;
        logic [7:0] c;
        r = 4 * int'(instr[1:0]);
        p.push_back({1'b0, tla});
        p.push_back({1'b0, pid});
        p.push_back({1'b0, instr});
        p.push_back({1'b0, 8'($urandom)});
        for (int i = 0; i < r; i++) p.push_back({1'b0, rv[8*(r-1-i) +: 8]});
        p.push_back({1'b0, 8'($urandom)});
        p.push_back({1'b0, tid[15:8]});
        p.push_back({1'b0, tid[7:0]});
        p.push_back({1'b0, 8'($urandom)});
        for (int i = 3; i >= 0; i--) p.push_back({1'b0, addr[8*i +: 8]});
        for (int i = 2; i >= 0; i--) p.push_back({1'b0, len[8*i +: 8]});
        c = model_crc(p, p.size()) ^ crc_xor;
        p.push_back({1'b0, c});
        for (int i = 0; i < ndata; i++) p.push_back({1'b0, 8'($urandom)});
        p.push_back({1'b1, term});
        return p;
    endfunction

    // Reference model: what one packet must produce at the three DUT outputs.
    task automatic predict(input chr_q_t p);
        int term, r, hl;
        exp_hdr_t e;
        logic [7:0] c;
        term = 0;
        while (!p[term][8]) term++;
        if (term == 0 || p[0][7:0] != LA || term == 1 || p[1][7:0] != 8'h01) begin
            exp_drop.push_back(1);
            return;
        end
        e = '{default: '0};
        r = (term > 2) ? 4 * int'(p[2][1:0]) : 0;
        hl = 16 + r;
        if (term == 2 || term < hl) begin
            e.status = (p[term][7:0] == 8'h00) ? 3'd2 : 3'd3;
            e.full = 0;
            exp_hdr.push_back(e);
            return;
        end
        e.full  = 1;
        e.instr = p[2][7:0];
        e.key   = p[3][7:0];
        for (int i = 0; i < r; i++) e.raddr = (e.raddr << 8) | 96'(p[4+i][7:0]);
        e.rlen  = 4'(r);
        e.init  = p[4+r][7:0];
        e.tid   = {p[5+r][7:0], p[6+r][7:0]};
        e.ext   = p[7+r][7:0];
        for (int i = 0; i < 4; i++) e.addr = (e.addr << 8) | 32'(p[8+r+i][7:0]);
        for (int i = 0; i < 3; i++) e.len = (e.len << 8) | 24'(p[12+r+i][7:0]);
        c = model_crc(p, hl);
        if (c != 8'h00)              e.status = 3'd1;
        else if (e.instr[7:6] != 2'b01) e.status = 3'd4;
        else                         e.status = 3'd0;
        exp_hdr.push_back(e);
        if (e.status == 3'd0)
            for (int i = hl; i <= term; i++) exp_data.push_back(p[i]);
    endtask

    task automatic send(input chr_q_t p, input bit arm);
        predict(p);
        if (arm) arm_first = 1;
        foreach (p[i]) fifo.push_back(p[i]);
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while ((fifo.size() != 0 || exp_hdr.size() != 0 || exp_data.size() != 0 ||
                exp_drop.size() != 0) && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("idle_reached", 96'(k < budget), 96'(1));
        repeat (3) @(negedge clk);
    endtask

    task automatic gen_random(output chr_q_t p);
        int kind, r2, cut;
        logic [7:0] instr, tla, pid, cx, term;
        chr_q_t full;
        kind  = $urandom_range(0, 10);
        r2    = $urandom_range(0, 3);
        instr = {2'b01, 4'($urandom), 2'(r2)};
        tla = LA; pid = 8'h01; cx = 8'h00;
        term = ($urandom_range(0, 1) == 1) ? 8'h01 : 8'h00;
        if (kind == 4) cx = 8'($urandom_range(1, 255));
        if (kind == 5) instr[7:6] = ($urandom_range(0, 2) == 0) ? 2'b00 : (($urandom_range(0, 1) == 1) ? 2'b10 : 2'b11);
        if (kind == 6) tla = 8'($urandom_range(0, 253));
        if (kind == 7) pid = 8'($urandom_range(2, 255));
        full = build_pkt(tla, pid, instr, {$urandom, $urandom, $urandom}, 16'($urandom),
                         $urandom, 24'($urandom), cx, $urandom_range(0, 6), term);
        if (kind == 8) begin
            cut = $urandom_range(0, 15 + 4 * r2);
            for (int i = 0; i < cut; i++) p.push_back(full[i]);
            p.push_back({1'b1, term});
        end else if (kind == 9) begin
            p.push_back({1'b1, term});
        end else begin
            p = full;
        end
    endtask

    // FIFO model and input driver: inputs change on the falling edge, pops follow the DUT's request.
    initial begin
        logic [8:0] tmp;
        bit empty_now;
        rxEmpty = 1'b1; rxDataOut = '0; hdrReady = 1'b0; dataReady = 1'b0;
        forever begin
            @(negedge clk);
            if (pop_pending) tmp = fifo.pop_front();
            gap_tog = !gap_tog;
            empty_now = (fifo.size() == 0) || (gap_mode == 1 && gap_tog) ||
                        (gap_mode == 2 && $urandom_range(0, 3) == 0);
            rxEmpty   = empty_now;
            rxDataOut = empty_now ? 9'($urandom) : fifo[0];
            hdrReady  = (hr_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
            if (dready_low > 0) begin
                dataReady = 1'b0;
                dready_low--;
            end else begin
                dataReady = (dr_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            #4;
            pop_pending = rstN && rxReadEnable && !rxEmpty;
            if (pop_pending && arm_first) begin
                first_pop_cyc = cyc;
                arm_first = 0;
            end
        end
    end

    // Monitor: compares whatever the DUT presents against the expectation queues.
    initial begin
        exp_hdr_t e;
        bit prev_hv, prev_hr, stalled;
        logic [2:0]  prev_status;
        logic [15:0] prev_tid;
        logic [8:0]  held_do;
        prev_hv = 0; prev_hr = 0; stalled = 0; prev_status = '0; prev_tid = '0; held_do = '0;
        forever begin
            @(negedge clk);
            #4;
            if (!rstN) begin
                prev_hv = 0; stalled = 0;
            end else begin
                check("rd_when_empty", 96'(rxReadEnable && rxEmpty), 96'(0));
                if (prev_hv && !prev_hr) begin
                    check("hdr_hold_valid", 96'(hdrValid), 96'(1));
                    check("hdr_hold_status", 96'(hdrStatus), 96'(prev_status));
                    check("hdr_hold_tid", 96'(transactionId), 96'(prev_tid));
                end
                if (hdrValid) begin
                    if (!prev_hv) begin
                        hdr_lat    = cyc - first_pop_cyc;
                        last_raddr = replyAddr;
                        last_rlen  = replyAddrLen;
                    end
                    check("hdr_expected", 96'(exp_hdr.size() != 0), 96'(1));
                    if (exp_hdr.size() != 0) begin
                        e = exp_hdr[0];
                        check("hdr_status", 96'(hdrStatus), 96'(e.status));
                        if (e.full) begin
                            check("instruction", 96'(instruction), 96'(e.instr));
                            check("key", 96'(key), 96'(e.key));
                            check("initiator", 96'(initiatorAddr), 96'(e.init));
                            check("tid", 96'(transactionId), 96'(e.tid));
                            check("ext_addr", 96'(extAddr), 96'(e.ext));
                            check("address", 96'(address), 96'(e.addr));
                            check("data_length", 96'(dataLength), 96'(e.len));
                            check("reply_addr", replyAddr, e.raddr);
                            check("reply_len", 96'(replyAddrLen), 96'(e.rlen));
                        end
                        if (hdrReady) void'(exp_hdr.pop_front());
                    end
                end
                if (dataValid) begin
                    check("data_expected", 96'(exp_data.size() != 0), 96'(1));
                    check("rd_vs_ready", 96'(rxReadEnable), 96'(dataReady));
                    if (stalled) check("data_hold", 96'(dataOut), 96'(held_do));
                    if (exp_data.size() != 0) begin
                        check("data_char", 96'(dataOut), 96'(exp_data[0]));
                        if (dataReady) void'(exp_data.pop_front());
                    end
                    if (dataReady) stalled = 0;
                    else begin
                        stalled = 1;
                        held_do = dataOut;
                    end
                end
                if (pktDropped) begin
                    check("drop_expected", 96'(exp_drop.size() != 0), 96'(1));
                    if (exp_drop.size() != 0) void'(exp_drop.pop_front());
                end
                prev_hv = hdrValid; prev_hr = hdrReady;
                prev_status = hdrStatus; prev_tid = transactionId;
            end
        end
    end

    initial begin
        chr_q_t p, full;
        int nb, k;
        rstN = 1'b0;
        repeat (3) @(negedge clk);
        #4;
        check("rst_rd", 96'(rxReadEnable), 96'(0));
        check("rst_hdr_valid", 96'(hdrValid), 96'(0));
        check("rst_status", 96'(hdrStatus), 96'(0));
        check("rst_instr", 96'(instruction), 96'(0));
        check("rst_tid", 96'(transactionId), 96'(0));
        check("rst_address", 96'(address), 96'(0));
        check("rst_length", 96'(dataLength), 96'(0));
        check("rst_reply", replyAddr, 96'(0));
        check("rst_reply_len", 96'(replyAddrLen), 96'(0));
        check("rst_data_valid", 96'(dataValid), 96'(0));
        check("rst_data_out", 96'(dataOut), 96'(0));
        check("rst_dropped", 96'(pktDropped), 96'(0));
        @(negedge clk);
        rstN = 1'b1;
        repeat (2) @(negedge clk);

        // Write command, R=0, continuous data.
        p = build_pkt(LA, 8'h01, 8'h6C, '0, 16'h1234, 32'hA000_0000, 24'd4, 8'h00, 4, 8'h00);
        send(p, 1);
        wait_idle(2000);
        check("latency_r0", 96'(hdr_lat), 96'(16));

        // Eight-byte reply address with leading zeros.
        p = build_pkt(LA, 8'h01, 8'h4E, 96'h0000_0001_0203_0405, 16'hBEEF, 32'h0000_1000,
                      24'd2, 8'h00, 2, 8'h00);
        send(p, 1);
        wait_idle(2000);
        check("latency_r8", 96'(hdr_lat), 96'(24));
        check("reply_r8", 96'(last_raddr[63:0]), 96'(64'h0000_0001_0203_0405));
        check("reply_len_r8", 96'(last_rlen), 96'(8));

        // Corrupted CRC, target mismatch, early EEP then a good packet.
        p = build_pkt(LA, 8'h01, 8'h6C, '0, 16'h1111, 32'h10, 24'd3, 8'h01, 3, 8'h00);
        send(p, 0);
        wait_idle(2000);
        p = build_pkt(8'h10, 8'h01, 8'h6C, '0, 16'h2222, 32'h20, 24'd3, 8'h00, 3, 8'h00);
        send(p, 0);
        wait_idle(2000);
        full = build_pkt(LA, 8'h01, 8'h6C, '0, 16'h3333, 32'h30, 24'd1, 8'h00, 1, 8'h00);
        p = {};
        for (int i = 0; i < 7; i++) p.push_back(full[i]);
        p.push_back({1'b1, 8'h01});
        send(p, 0);
        send(full, 0);
        wait_idle(2000);

        // Bursty FIFO plus a five-cycle consumer stall in the payload.
        gap_mode = 1;
        p = build_pkt(LA, 8'h01, 8'h6D, 96'h0A0B_0C0D, 16'h4444, 32'h40, 24'd6, 8'h00, 6, 8'h01);
        send(p, 0);
        k = 0;
        while (!dataValid && k < 500) begin
            @(negedge clk);
            k++;
        end
        check("payload_seen", 96'(k < 500), 96'(1));
        dready_low = 5;
        wait_idle(2000);
        gap_mode = 0;

        for (int it = 0; it < 120; it++) begin
            gap_mode = $urandom_range(0, 2);
            hr_mode  = $urandom_range(0, 1);
            dr_mode  = $urandom_range(0, 1);
            nb = $urandom_range(1, 3);
            for (int b = 0; b < nb; b++) begin
                p = {};
                gen_random(p);
                send(p, 0);
            end
            wait_idle(3000);
        end

        check("leftover", 96'(fifo.size() + exp_hdr.size() + exp_data.size() + exp_drop.size()),
              96'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
